// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges pipeline and aux-unit GPR writebacks into one registered RF write port.
// Aux results queue in a FIFO; a pipeline write squashes any older queued write to the same register.
module rf_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_addr,
  input  logic [31:0]   pipe_data,
  input  logic          aux_valid,
  output logic          aux_ready,
  input  logic [4:0]    aux_addr,
  input  logic [31:0]   aux_data,
  output logic          rf_we,
  output logic [4:0]    rf_addr,
  output logic [31:0]   rf_data,
  input  logic [4:0]    query_addr_1,
  input  logic [4:0]    query_addr_2,
  output logic          pending_1,
  output logic          pending_2,
  output logic [AW:0]   count
);
  logic [DEPTH-1:0] vld;
  logic [4:0]       fa [DEPTH];
  logic [31:0]      fd [DEPTH];
  logic [AW-1:0]    rp, wp;
  logic             preq, push, pop, hit_1, hit_2;
  assign preq = pipe_we && pipe_addr != 5'd0;
  assign aux_ready = reset && (count < (AW+1)'(DEPTH));
  assign pop = !preq && count != '0;
  // an aux result to the register the pipeline writes now is already stale
  assign push = aux_valid && aux_ready && aux_addr != 5'd0 && !(preq && aux_addr == pipe_addr);
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      count <= '0;
      vld <= '0;
      rp <= '0;
      wp <= '0;
    end else begin
      rf_we <= preq || (pop && vld[rp]);
      if (preq) begin
        rf_addr <= pipe_addr;
        rf_data <= pipe_data;
      end else if (pop) begin
        rf_addr <= fa[rp];
        rf_data <= fd[rp];
      end
      for (int i = 0; i < DEPTH; i++)
        if (preq && fa[i] == pipe_addr) vld[i] <= 1'b0;
      if (pop) begin
        vld[rp] <= 1'b0;
        rp <= rp + AW'(1);
      end
      if (push) begin
        vld[wp] <= 1'b1;
        wp <= wp + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wp] <= aux_addr;
      fd[wp] <= aux_data;
    end
  end
  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_1 = hit_1 || (vld[i] && fa[i] == query_addr_1);
      hit_2 = hit_2 || (vld[i] && fa[i] == query_addr_2);
    end
    pending_1 = query_addr_1 != 5'd0 && (hit_1 || (rf_we && rf_addr == query_addr_1));
    pending_2 = query_addr_2 != 5'd0 && (hit_2 || (rf_we && rf_addr == query_addr_2));
  end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed test-plan checks plus random traffic compared every cycle
// against a queue-based model of the writeback arbiter.
module tb_rf_writeback_arbiter;
  logic clk = 0, reset = 0;
  logic pipe_we = 0, aux_valid = 0;
  logic [4:0] pipe_addr = 0, aux_addr = 0, query_addr_1 = 0, query_addr_2 = 0;
  logic [31:0] pipe_data = 0, aux_data = 0;
  logic aux_ready, rf_we, pending_1, pending_2;
  logic [4:0] rf_addr;
  logic [31:0] rf_data;
  logic [2:0] count;
  int checks = 0, errors = 0;

  rf_writeback_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .query_addr_1(query_addr_1),
    .query_addr_2(query_addr_2), .pending_1(pending_1), .pending_2(pending_2), .count(count));

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // reference model: the FIFO is a queue of pending aux writes, squash clears a flag
  typedef struct {bit v; bit [4:0] a; bit [31:0] d;} ent_t;
  ent_t q[$];
  bit m_we = 0, m_ok = 0;
  bit [4:0] m_addr = 0;
  bit [31:0] m_data = 0;

  always @(posedge clk) begin
    bit preq, rdy;
    ent_t h, e;
    if (!reset) begin
      q.delete();
      m_we = 0; m_addr = 0; m_data = 0; m_ok = 1;
    end else begin
      preq = pipe_we && pipe_addr != 0;
      rdy = q.size() < 4;
      m_we = 0;
      if (preq) begin
        m_we = 1; m_addr = pipe_addr; m_data = pipe_data;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (h.v) begin m_we = 1; m_addr = h.a; m_data = h.d; end
      end
      foreach (q[i]) if (preq && q[i].a == pipe_addr) q[i].v = 0;
      if (aux_valid && rdy && aux_addr != 0 && !(preq && aux_addr == pipe_addr)) begin
        e.v = 1; e.a = aux_addr; e.d = aux_data;
        q.push_back(e);
      end
    end
  end

  function automatic bit m_pend(bit [4:0] qa);
    bit hit = m_we && m_addr == qa;
    foreach (q[i]) if (q[i].v && q[i].a == qa) hit = 1;
    return qa != 0 && hit;
  endfunction

  always @(negedge clk) if (m_ok) begin
    chk("aux_ready", aux_ready, reset && q.size() < 4);
    chk("count", count, q.size());
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_addr", rf_addr, m_addr);
      chk("rf_data", rf_data, m_data);
    end
    chk("pending_1", pending_1, m_pend(query_addr_1));
    chk("pending_2", pending_2, m_pend(query_addr_2));
  end

  task automatic set(bit pw, bit [4:0] pa, bit [31:0] pd, bit av, bit [4:0] aa, bit [31:0] ad);
    pipe_we = pw; pipe_addr = pa; pipe_data = pd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset holds everything idle even with requests present
    set(1, 3, 32'h77, 1, 4, 32'h99);
    tick(); tick();
    chk("rst aux_ready", aux_ready, 0);
    chk("rst rf_we", rf_we, 0);
    chk("rst rf_addr", rf_addr, 0);
    chk("rst rf_data", rf_data, 0);
    chk("rst count", count, 0);
    reset = 1;
    set(0, 0, 0, 0, 0, 0);
    #1;
    chk("rel aux_ready", aux_ready, 1);
    tick();
    chk("rel count", count, 0);
    // pipeline latency and addr 0 ignore
    set(1, 5, 32'h1234, 0, 0, 0);
    tick();
    chk("pipe we", rf_we, 1);
    chk("pipe addr", rf_addr, 5);
    chk("pipe data", rf_data, 32'h1234);
    set(1, 0, 32'h5555, 0, 0, 0);
    tick();
    chk("x0 we", rf_we, 0);
    // fill while the pipeline hogs the port
    for (int i = 0; i < 4; i++) begin
      set(1, 8, i, 1, 5'(16 + i), 32'h10 + i);
      tick();
    end
    set(1, 8, 32'h8, 1, 20, 32'h14);
    #1;
    chk("full count", count, 4);
    chk("full ready", aux_ready, 0);
    tick();
    chk("held count", count, 4);
    set(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain we", rf_we, 1);
      chk("drain addr", rf_addr, 16 + i);
      chk("drain data", rf_data, 32'h10 + i);
    end
    chk("drain count", count, 0);
    // squash of an older queued write
    set(1, 8, 0, 1, 9, 32'hAAAA);
    tick();
    set(1, 9, 32'hBBBB, 0, 0, 0);
    tick();
    chk("sq data", rf_data, 32'hBBBB);
    chk("sq count", count, 1);
    set(0, 0, 0, 0, 0, 0);
    tick();
    chk("sq pop we", rf_we, 0);
    chk("sq pop count", count, 0);
    set(1, 9, 32'hCCCC, 1, 9, 32'hDDDD);
    tick();
    chk("same count", count, 0);
    chk("same data", rf_data, 32'hCCCC);
    set(0, 0, 0, 0, 0, 0);
    tick();
    chk("same idle we", rf_we, 0);
    // pending flags
    set(1, 8, 0, 1, 10, 32'h1010);
    query_addr_1 = 10; query_addr_2 = 0;
    tick();
    set(0, 0, 0, 0, 0, 0);
    #1;
    chk("pend q", pending_1, 1);
    chk("pend zero", pending_2, 0);
    tick();
    chk("pend rf", pending_1, 1);
    tick();
    chk("pend gone", pending_1, 0);
    // reset mid-drain discards queued writes
    for (int i = 0; i < 3; i++) begin
      set(1, 8, 0, 1, 5'(20 + i), 32'h20 + i);
      tick();
    end
    chk("pre rst count", count, 3);
    set(0, 0, 0, 0, 0, 0);
    reset = 0;
    tick();
    chk("mid rst count", count, 0);
    chk("mid rst we", rf_we, 0);
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post rst we", rf_we, 0);
    end
    // random traffic on a small register set to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      int pp = (n / 500) % 2 ? 30 : 75;
      reset = $urandom_range(99) >= 2;
      set($urandom_range(99) < pp, 5'($urandom_range(7)), $urandom,
          $urandom_range(99) < 60, 5'($urandom_range(7)), $urandom);
      query_addr_1 = 5'($urandom_range(7));
      query_addr_2 = 5'($urandom_range(7));
      tick();
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
